// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring divider for the ALU's DIV/DIVU/MOD instructions.
//   Each RUN cycle performs one shift-and-subtract step. Signed operands are
//   divided as magnitudes, and the result signs are restored in a single FIX
//   cycle. The controller starts a division with start and stalls until done.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset
//   start    in   1      request, sampled only in IDLE
//   func     in   1      0 = unsigned, 1 = signed (two's complement)
//   X        in   WIDTH  dividend, captured when start is accepted
//   Y        in   WIDTH  divisor, captured when start is accepted
//   Q        out  WIDTH  quotient (registered)
//   R        out  WIDTH  remainder (registered)
//   busy     out  1      high in RUN and FIX
//   done     out  1      one-cycle completion pulse
//   div_zero out  1      set with done when the captured divisor was zero
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             func,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH:0]   rem_q;     // one extra bit so the compare cannot overflow
   logic [WIDTH-1:0] quo_q;     // dividend bits shift out as quotient bits shift in
   logic [WIDTH-1:0] ymag_q;
   logic             sign_q_q;
   logic             sign_r_q;
   logic [WIDTH-1:0] q_q, r_q;
   logic             busy_q, done_q, div_zero_q;

   logic [WIDTH:0]   rem_sh, rem_d;
   logic [WIDTH-1:0] quo_d;
   logic [WIDTH-1:0] xmag, ymag;
   logic [WIDTH-1:0] q_fix, r_fix;

   // Operand magnitudes at accept time. The most negative value maps onto
   // itself, which reads correctly as 2^(WIDTH-1) when treated as unsigned.
   always_comb begin
      xmag = (func && X[WIDTH-1]) ? -X : X;
      ymag = (func && Y[WIDTH-1]) ? -Y : Y;
   end

   // One restoring step.
   always_comb begin
      rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      rem_d  = rem_sh;
      quo_d  = {quo_q[WIDTH-2:0], 1'b0};
      if (rem_sh >= {1'b0, ymag_q}) begin
         rem_d = rem_sh - {1'b0, ymag_q};
         quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end
   end

   // Sign restoration. The quotient truncates toward zero, and the remainder
   // follows the sign of the dividend.
   always_comb begin
      q_fix = sign_q_q ? -quo_q : quo_q;
      r_fix = sign_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         ymag_q     <= '0;
         sign_q_q   <= 1'b0;
         sign_r_q   <= 1'b0;
         q_q        <= '0;
         r_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  div_zero_q <= 1'b0;
                  if (Y == '0) begin
                     // Skip the iteration entirely and report the fixed result.
                     q_q        <= '1;
                     r_q        <= X;
                     div_zero_q <= 1'b1;
                     done_q     <= 1'b1;
                     state_q    <= S_DONE;
                  end else begin
                     rem_q    <= '0;
                     quo_q    <= xmag;
                     ymag_q   <= ymag;
                     sign_q_q <= func & (X[WIDTH-1] ^ Y[WIDTH-1]);
                     sign_r_q <= func & X[WIDTH-1];
                     cnt_q    <= CNT_LAST;
                     busy_q   <= 1'b1;
                     state_q  <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               if (cnt_q == '0) state_q <= S_FIX;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            S_FIX: begin
               q_q     <= q_fix;
               r_q     <= r_fix;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               // Any start seen here is dropped, not held for IDLE.
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign Q        = q_q;
   assign R        = r_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32). Expected results are queued when
// an operation is launched and popped when done is observed.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst, start, func;
   logic [31:0] X, Y;
   logic [31:0] Q, R;
   logic        busy, done, div_zero;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       tag;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      int          lat;
   } exp_t;

   exp_t sb[$];

   seq_divider #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .func(func), .X(X), .Y(Y),
      .Q(Q), .R(R), .busy(busy), .done(done), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] q, input logic [31:0] r,
                       input logic dz, input int lat);
      exp_t e;
      e.tag = tag; e.q = q; e.r = r; e.dz = dz; e.lat = lat;
      sb.push_back(e);
   endtask

   // Drive one start pulse. The operands are scrambled after the accepting
   // edge to prove that they were captured.
   task automatic start_op(input logic f, input logic [31:0] x, input logic [31:0] y);
      func = f; X = x; Y = y; start = 1'b1;
      tick();
      start = 1'b0; X = $urandom; Y = $urandom; func = $urandom_range(0, 1);
   endtask

   // Wait for done, with n0 edges already elapsed since acceptance (the
   // accepting edge counts as 1). Returns during the done cycle.
   task automatic wait_done(input int n0);
      exp_t e;
      int   n = n0;
      logic busy_bad = 1'b0;
      while (!done && n < 100) begin
         if (!busy) busy_bad = 1'b1;
         tick();
         n++;
      end
      e = sb.pop_front();
      check({e.tag, ".done_seen"}, done, 1'b1);
      check({e.tag, ".latency"}, n, e.lat);
      check({e.tag, ".Q"}, Q, e.q);
      check({e.tag, ".R"}, R, e.r);
      check({e.tag, ".div_zero"}, div_zero, e.dz);
      check({e.tag, ".busy_at_done"}, busy, 1'b0);
      if (e.lat > 1) check({e.tag, ".busy_during_run"}, busy_bad, 1'b0);
   endtask

   // Leave the done cycle, optionally holding start high during it.
   task automatic after_done(input string tag, input logic poke);
      if (poke) begin start = 1'b1; func = 1'b0; X = 32'd9; Y = 32'd3; end
      tick();
      start = 1'b0;
      check({tag, ".done_pulse"}, done, 1'b0);
      tick();
      check({tag, ".idle_busy"}, busy, 1'b0);
   endtask

   task automatic no_done_for(input string tag, input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (done) seen++;
      end
      check({tag, ".no_done"}, seen, 0);
   endtask

   initial begin
      logic [31:0]        rx, ry;
      logic signed [31:0] sx, sy;

      rst = 1'b1; start = 1'b0; func = 1'b0; X = '0; Y = '0;
      repeat (3) tick();
      check("reset.Q", Q, 32'h0);
      check("reset.R", R, 32'h0);
      check("reset.busy", busy, 1'b0);
      check("reset.done", done, 1'b0);
      check("reset.div_zero", div_zero, 1'b0);
      rst = 1'b0;
      tick();

      // 1: unsigned 100/7; start is held high in the done cycle and must be ignored
      push("t1_100_7", 32'd14, 32'd2, 1'b0, 34);
      start_op(1'b0, 32'd100, 32'd7);
      wait_done(1);
      after_done("t1", 1'b1);
      no_done_for("t1_poke", 40);

      // 2: signed, truncation toward zero
      push("t2_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
      start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_done(1);
      after_done("t2a", 1'b0);
      push("t2_7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
      start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
      wait_done(1);
      after_done("t2b", 1'b0);

      // 3: divide by zero
      push("t3_div0", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1);
      start_op(1'b0, 32'h1234_5678, 32'h0);
      wait_done(1);
      after_done("t3", 1'b0);
      check("t3.dz_holds", div_zero, 1'b1);

      // 4: signed overflow wraps; the unsigned case uses the same operands
      push("t4_ovf_s", 32'h8000_0000, 32'h0, 1'b0, 34);
      start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      check("t4.dz_cleared_on_start", div_zero, 1'b0);
      wait_done(1);
      after_done("t4a", 1'b0);
      push("t4_ovf_u", 32'h0, 32'h8000_0000, 1'b0, 34);
      start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(1);
      after_done("t4b", 1'b0);

      // 5: start while busy is ignored
      push("t5_50_5", 32'd10, 32'd0, 1'b0, 34);
      start_op(1'b0, 32'd50, 32'd5);
      repeat (8) tick();
      start = 1'b1; func = 1'b0; X = 32'd9; Y = 32'd3;
      tick();
      start = 1'b0;
      wait_done(10);
      after_done("t5", 1'b0);
      no_done_for("t5_single", 40);
      check("t5.Q_holds", Q, 32'd10);

      // 6: reset mid-operation aborts, then restart
      start_op(1'b0, 32'd1000, 32'd7);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6.busy_after_rst", busy, 1'b0);
      check("t6.Q_after_rst", Q, 32'h0);
      check("t6.R_after_rst", R, 32'h0);
      no_done_for("t6_abort", 40);
      push("t6_9_3", 32'd3, 32'd0, 1'b0, 34);
      start_op(1'b0, 32'd9, 32'd3);
      wait_done(1);
      after_done("t6", 1'b0);

      // Random operands against the language's own division operators
      for (int i = 0; i < 6; i++) begin
         rx = $urandom;
         ry = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
         if (ry == 0) ry = 32'd1;
         if (i < 3) begin
            push($sformatf("rnd_u%0d", i), rx / ry, rx % ry, 1'b0, 34);
            start_op(1'b0, rx, ry);
         end else begin
            sx = rx; sy = (i == 4) ? -$signed(ry) : $signed(ry);
            if (sx == 32'sh8000_0000) sx = 32'sd12345;
            push($sformatf("rnd_s%0d", i), sx / sy, sx % sy, 1'b0, 34);
            start_op(1'b1, sx, sy);
         end
         wait_done(1);
         after_done("rnd", 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
